wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 CLK  input  1  clock; all state changes on posedge CLK.
REQ-003 CLR  input  1  synchronous active-high reset.
REQ-004 WR_VALID  input  1  producer offers a register write this cycle.
REQ-005 WR_READY  output  1  queue can accept; high when COUNT != 4.
REQ-006 WR_REG  input  4  destination register index R0..R15.
REQ-007 WR_DATA  input  32  write data.
REQ-008 RF_HOLD  input  1  register file stall; no drain while high.
REQ-009 RF_EN_N  output  1  active-low register-file write enable, drives the decoder enable.
REQ-010 RF_SEL  output  4  register index of head entry, drives the write decoder select.
REQ-011 RF_DATA  output  32  head entry data, drives the register data input.
REQ-012 RA, RB  input  4 each  read-port selects also presented to the register file.
REQ-013 HIT_A, HIT_B  output  1 each  a pending entry targets RA / RB.
REQ-014 BYP_A, BYP_B  output  32 each  data of the newest pending entry matching RA / RB.
REQ-015 COUNT  output  3  occupied entries, 0..4.

Function
REQ-016 Storage SHALL be a 4-entry in-order FIFO of {reg[3:0], data[31:0]} with 2-bit head/tail pointers wrapping 3->0.
REQ-017 Push SHALL occur at posedge when WR_VALID && WR_READY; WR_VALID with WR_READY low is ignored, with no state change.
REQ-018 Drain SHALL occur at posedge when COUNT != 0 && !RF_HOLD; the head entry is retired on that same edge the register file captures it.
REQ-019 RF_EN_N SHALL be combinational: 0 iff COUNT != 0 && !RF_HOLD, otherwise 1.
REQ-020 RF_SEL/RF_DATA SHALL show the head entry combinationally, and are 0 when COUNT == 0.
REQ-021 Simultaneous push and drain SHALL leave COUNT unchanged; push is still refused when COUNT == 4, even if draining.
REQ-022 Write latency SHALL be a minimum of one cycle: an entry pushed into an empty queue drives RF_EN_N low in the next cycle.
REQ-023 Multiple entries to the same register SHALL drain in push order; none are merged or dropped.
REQ-024 The bypass search SHALL cover occupied entries only (not WR_DATA in flight); the newest match wins; no match gives HIT=0 and BYP=0.
REQ-025 An entry being drained this cycle SHALL still count as a bypass hit in that cycle.
REQ-026 COUNT SHALL never exceed 4 nor underflow below 0.

Reset
REQ-027 On CLR=1 at posedge: COUNT=0, head=tail=0, all entry contents cleared to 0.
REQ-028 After CLR=1, outputs SHALL be: WR_READY=1, RF_EN_N=1, RF_SEL=0, RF_DATA=0, HIT_A=HIT_B=0, BYP_A=BYP_B=0.
REQ-029 CLR SHALL take priority over a simultaneous push or drain; pending writes are discarded.

Configuration
REQ-030 Macro WBQ_BYPASS_EN: when defined, the HIT/BYP logic of REQ-024/025 is compiled in.
REQ-031 Without WBQ_BYPASS_EN, ports SHALL remain present and HIT_A, HIT_B, BYP_A, BYP_B are tied to 0; queue behaviour is unchanged.

Verification
REQ-032 CLR pulse, then push {R3, 0x0000_00A5}, RF_HOLD=0 -> next cycle RF_EN_N=0, RF_SEL=3, RF_DATA=0xA5; following cycle COUNT=0, RF_EN_N=1.
REQ-033 RF_HOLD=1, push R1..R5 with data 0x11..0x55 on consecutive cycles -> the 5th push is refused with WR_READY=0, COUNT=4; release hold -> R1..R4 drain in order over 4 cycles.
REQ-034 Hold queue with entries {R2,0x10},{R7,0x20},{R2,0x30}; RA=2, RB=7 -> HIT_A=1, BYP_A=0x30, HIT_B=1, BYP_B=0x20; RA=9 -> HIT_A=0, BYP_A=0.
REQ-035 COUNT=4 with hold released and WR_VALID=1 -> push refused and drain happens, COUNT=3; next cycle the push is accepted and drained, COUNT stays 3.
REQ-036 COUNT=3, assert CLR with WR_VALID=1 -> COUNT=0, RF_EN_N=1, no register write issued afterward.
REQ-037 Build without WBQ_BYPASS_EN, repeat REQ-034 stimulus -> all HIT/BYP outputs are 0, and drain order matches REQ-033.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: a 4-entry in-order write-back queue sitting in front of a register file.
// Entries are {reg[3:0], data[31:0]}. The head entry drives the register-file write
// port combinationally and retires on the same edge that the register file captures it.
// Optional feature: define WBQ_BYPASS_EN to compile in the read-port bypass search
// (HIT/BYP). Without the macro those outputs stay present and are tied to 0.
module wb_queue (
   input  logic        i_clk,
   input  logic        i_clr,
   input  logic        i_wr_valid,
   output logic        o_wr_ready,
   input  logic [3:0]  i_wr_reg,
   input  logic [31:0] i_wr_data,
   input  logic        i_rf_hold,
   output logic        o_rf_en_n,
   output logic [3:0]  o_rf_sel,
   output logic [31:0] o_rf_data,
   input  logic [3:0]  i_ra,
   input  logic [3:0]  i_rb,
   output logic        o_hit_a,
   output logic        o_hit_b,
   output logic [31:0] o_byp_a,
   output logic [31:0] o_byp_b,
   output logic [2:0]  o_count
);

   localparam int DEPTH = 4;

   logic [DEPTH-1:0][3:0]  r_reg;
   logic [DEPTH-1:0][31:0] r_data;
   logic [1:0]             r_head;
   logic [1:0]             r_tail;
   logic [2:0]             r_count;

   logic w_push;
   logic w_drain;
   logic w_full;
   logic w_empty;

   assign w_full  = (r_count == 3'd4);
   assign w_empty = (r_count == 3'd0);
   // A full queue refuses pushes even while it drains, so the ready path never
   // depends on the register-file hold.
   assign w_push  = i_wr_valid && !w_full;
   assign w_drain = !w_empty && !i_rf_hold;

   // Pointer, occupancy and entry storage update; clear wipes everything.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_reg   <= '0;
         r_data  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_reg[r_tail]  <= i_wr_reg;
            r_data[r_tail] <= i_wr_data;
            r_tail         <= r_tail + 2'd1;
         end
         if (w_drain) begin
            r_head <= r_head + 2'd1;
         end
         case ({w_push, w_drain})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_wr_ready = !w_full;
   assign o_count    = r_count;
   assign o_rf_en_n  = !w_drain;
   // Stale storage past the head is masked so an empty queue presents zeros.
   assign o_rf_sel   = w_empty ? 4'd0  : r_reg[r_head];
   assign o_rf_data  = w_empty ? 32'd0 : r_data[r_head];

`ifdef WBQ_BYPASS_EN
   // Slot k is the k-th oldest occupied entry; it is valid when k < count.
   logic [DEPTH-1:0][1:0] w_slot_idx;
   logic [DEPTH-1:0]      w_slot_vld;

   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      assign w_slot_idx[k] = r_head + 2'(k);
      assign w_slot_vld[k] = (3'(k) < r_count);
   end

   // Scan oldest to newest so the newest matching entry overwrites older ones.
   // The head entry counts even on the cycle it is being drained.
   always_comb begin
      o_hit_a = 1'b0;
      o_hit_b = 1'b0;
      o_byp_a = '0;
      o_byp_b = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (w_slot_vld[k] && (r_reg[w_slot_idx[k]] == i_ra)) begin
            o_hit_a = 1'b1;
            o_byp_a = r_data[w_slot_idx[k]];
         end
         if (w_slot_vld[k] && (r_reg[w_slot_idx[k]] == i_rb)) begin
            o_hit_b = 1'b1;
            o_byp_b = r_data[w_slot_idx[k]];
         end
      end
   end
`else
   // Read selects only feed the register file in this build.
   logic w_unused_rd;
   assign w_unused_rd = ^{i_ra, i_rb};
   assign o_hit_a = 1'b0;
   assign o_hit_b = 1'b0;
   assign o_byp_a = '0;
   assign o_byp_b = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue. Bypass expectations follow WBQ_BYPASS_EN.
module tb_wb_queue;

`ifdef WBQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [3:0]  wr_reg = '0;
   logic [31:0] wr_data = '0;
   logic        rf_hold = 1'b0;
   logic        rf_en_n;
   logic [3:0]  rf_sel;
   logic [31:0] rf_data;
   logic [3:0]  ra = '0;
   logic [3:0]  rb = '0;
   logic        hit_a, hit_b;
   logic [31:0] byp_a, byp_b;
   logic [2:0]  count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_queue dut (
      .i_clk(clk), .i_clr(clr), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
      .i_wr_reg(wr_reg), .i_wr_data(wr_data), .i_rf_hold(rf_hold),
      .o_rf_en_n(rf_en_n), .o_rf_sel(rf_sel), .o_rf_data(rf_data),
      .i_ra(ra), .i_rb(rb), .o_hit_a(hit_a), .o_hit_b(hit_b),
      .o_byp_a(byp_a), .o_byp_b(byp_b), .o_count(count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are then changed 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic head(input string tag, input logic en_n, input logic [3:0] sel, input logic [31:0] d);
      chk({tag, ".en_n"}, 32'(rf_en_n), 32'(en_n));
      chk({tag, ".sel"},  32'(rf_sel),  32'(sel));
      chk({tag, ".data"}, rf_data, d);
   endtask

   task automatic push(input logic [3:0] r, input logic [31:0] d);
      wr_valid = 1'b1; wr_reg = r; wr_data = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      #1;
      // Reset state
      do_clr();
      settle();
      chk("rst.count", 32'(count), 0);
      chk("rst.ready", 32'(wr_ready), 1);
      head("rst", 1'b1, 4'd0, 32'd0);
      chk("rst.hit_a", 32'(hit_a), 0);
      chk("rst.hit_b", 32'(hit_b), 0);
      chk("rst.byp_a", byp_a, 0);
      chk("rst.byp_b", byp_b, 0);

      // Single write, one-cycle latency
      rf_hold = 1'b0;
      push(4'd3, 32'h0000_00A5);
      settle();
      chk("lat.count", 32'(count), 1);
      head("lat", 1'b0, 4'd3, 32'hA5);
      tick();
      settle();
      chk("lat.count2", 32'(count), 0);
      head("lat2", 1'b1, 4'd0, 32'd0);

      // Fill under hold; fifth push refused
      rf_hold = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wr_valid = 1'b1; wr_reg = 4'(i); wr_data = 32'(i * 'h11);
         settle();
         chk($sformatf("fill.ready%0d", i), 32'(wr_ready), (i <= 4) ? 1 : 0);
         chk($sformatf("fill.en_n%0d", i), 32'(rf_en_n), 1);
         tick();
      end
      wr_valid = 1'b0;
      settle();
      chk("fill.count", 32'(count), 4);
      rf_hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         settle();
         head($sformatf("drain%0d", i), 1'b0, 4'(i), 32'(i * 'h11));
         tick();
      end
      settle();
      chk("drain.count", 32'(count), 0);
      chk("drain.en_n", 32'(rf_en_n), 1);

      // Bypass: newest match wins
      rf_hold = 1'b1;
      push(4'd2, 32'h10);
      push(4'd7, 32'h20);
      push(4'd2, 32'h30);
      ra = 4'd2; rb = 4'd7;
      settle();
      chk("byp.count", 32'(count), 3);
      chk("byp.hit_a", 32'(hit_a), 32'(BYP));
      chk("byp.byp_a", byp_a, BYP ? 32'h30 : 32'h0);
      chk("byp.hit_b", 32'(hit_b), 32'(BYP));
      chk("byp.byp_b", byp_b, BYP ? 32'h20 : 32'h0);
      ra = 4'd9;
      settle();
      chk("byp.miss_hit", 32'(hit_a), 0);
      chk("byp.miss_byp", byp_a, 0);
      // Drain with bypass still reporting the retiring entry
      rf_hold = 1'b0; ra = 4'd2; rb = 4'd7;
      settle();
      head("bd1", 1'b0, 4'd2, 32'h10);
      tick();
      settle();
      head("bd2", 1'b0, 4'd7, 32'h20);
      chk("bd2.hit_b", 32'(hit_b), 32'(BYP));
      chk("bd2.byp_b", byp_b, BYP ? 32'h20 : 32'h0);
      tick();
      settle();
      head("bd3", 1'b0, 4'd2, 32'h30);
      chk("bd3.hit_a", 32'(hit_a), 32'(BYP));
      chk("bd3.byp_a", byp_a, BYP ? 32'h30 : 32'h0);
      chk("bd3.hit_b", 32'(hit_b), 0);
      tick();
      settle();
      chk("bd.count", 32'(count), 0);
      chk("bd.hit_a", 32'(hit_a), 0);

      // Full with drain: push refused, then accepted while draining
      rf_hold = 1'b1;
      for (int i = 1; i <= 4; i++) push(4'(i), 32'(i * 'h11));
      rf_hold = 1'b0; wr_valid = 1'b1; wr_reg = 4'd8; wr_data = 32'h88;
      settle();
      chk("fd.ready0", 32'(wr_ready), 0);
      chk("fd.en_n0", 32'(rf_en_n), 0);
      tick();
      settle();
      chk("fd.count1", 32'(count), 3);
      chk("fd.ready1", 32'(wr_ready), 1);
      tick();
      wr_valid = 1'b0;
      settle();
      chk("fd.count2", 32'(count), 3);
      head("fd.h3", 1'b0, 4'd3, 32'h33);
      tick();
      settle();
      head("fd.h4", 1'b0, 4'd4, 32'h44);
      tick();
      settle();
      head("fd.h8", 1'b0, 4'd8, 32'h88);
      tick();
      settle();
      chk("fd.count3", 32'(count), 0);

      // Clear beats simultaneous push and drain
      rf_hold = 1'b1;
      push(4'd5, 32'h55);
      push(4'd6, 32'h66);
      push(4'd7, 32'h77);
      settle();
      chk("clr.pre", 32'(count), 3);
      rf_hold = 1'b0; clr = 1'b1; wr_valid = 1'b1; wr_reg = 4'd9; wr_data = 32'h99;
      tick();
      clr = 1'b0; wr_valid = 1'b0;
      settle();
      chk("clr.count", 32'(count), 0);
      chk("clr.ready", 32'(wr_ready), 1);
      head("clr", 1'b1, 4'd0, 32'd0);
      tick();
      settle();
      chk("clr.count2", 32'(count), 0);
      chk("clr.en_n2", 32'(rf_en_n), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
